// File: rtl/gray_count_receiver.sv
// Receive side of a Gray-code counter link: synchronizes the incoming Gray count,
// decodes it to binary and classifies every change as a legal step, a backward move or a skip.
module gray_count_receiver #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 enable,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 locked,
  output logic                 step,
  output logic                 back_err,
  output logic                 skip_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {ACQUIRE, TRACK} state_t;

  localparam int                FILL_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);
  localparam logic [WIDTH-1:0]  D_STEP   = WIDTH'(1);
  localparam logic [WIDTH-1:0]  D_BACK   = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] diff;

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [WIDTH-1:0]    bin_d;
  logic                locked_d, step_d, back_d, skip_d, err_hit;
  logic                sticky_d;
  logic [ERR_CNT_W-1:0] count_d;

  // NOTE: the synchronizer is a handful of flops, not a RAM, so it is reset like any
  // other state to give a defined value at the first lock after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_last = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    cur = '0;
    for (int i = 0; i < WIDTH; i++) cur[i] = ^(s_last >> i);
  end

  assign diff = cur - bin_out;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACQUIRE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable)                                      state_d = ACQUIRE;
    else if (state_q == ACQUIRE && fill_q == FILL_MAX) state_d = TRACK;
  end

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    fill_d   = fill_q;
    bin_d    = bin_out;
    locked_d = locked;
    step_d   = 1'b0;
    back_d   = 1'b0;
    skip_d   = 1'b0;
    if (!enable) begin
      fill_d   = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        ACQUIRE: begin
          if (fill_q == FILL_MAX) begin
            bin_d    = cur;
            locked_d = 1'b1;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        TRACK: begin
          if (diff != '0) begin
            bin_d = cur;
            if (diff == D_STEP)      step_d = 1'b1;
            else if (diff == D_BACK) back_d = 1'b1;
            else                     skip_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A new error on the same edge as err_clr wins: the count restarts at one.
  always_comb begin
    err_hit  = back_d | skip_d;
    sticky_d = err_sticky;
    count_d  = err_count;
    if (err_hit) begin
      sticky_d = 1'b1;
      if (err_clr)                 count_d = ERR_CNT_W'(1);
      else if (err_count != CNT_MAX) count_d = err_count + 1'b1;
    end else if (err_clr) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q     <= '0;
      bin_out    <= '0;
      locked     <= 1'b0;
      step       <= 1'b0;
      back_err   <= 1'b0;
      skip_err   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      fill_q     <= fill_d;
      bin_out    <= bin_d;
      locked     <= locked_d;
      step       <= step_d;
      back_err   <= back_d;
      skip_err   <= skip_d;
      err_sticky <= sticky_d;
      err_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_gray_count_receiver.sv
// Scoreboard bench for gray_count_receiver: stimulus queues expected events,
// a negedge monitor pops and compares whenever the DUT reports a lock or a pulse.
module tb_gray_count_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] gray_in;
  logic       enable;
  logic       err_clr;
  logic [2:0] bin_out;
  logic       locked, step, back_err, skip_err, err_sticky;
  logic [1:0] err_count;

  typedef enum int {EV_LOCK, EV_STEP, EV_BACK, EV_SKIP} ev_t;
  typedef struct {
    ev_t        kind;
    logic [2:0] bin;
    logic [1:0] cnt;
    logic       sticky;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic locked_prev = 1'b0;

  gray_count_receiver #(.WIDTH(3), .SYNC_STAGES(2), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .enable(enable), .err_clr(err_clr),
    .bin_out(bin_out), .locked(locked), .step(step), .back_err(back_err),
    .skip_err(skip_err), .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_t k, input logic [2:0] b, input logic [1:0] c, input logic s);
    exp_t e;
    e.kind = k; e.bin = b; e.cnt = c; e.sticky = s;
    q.push_back(e);
  endtask

  // Apply a Gray value, queue its expected event, and hold it for four clocks.
  task automatic drive(input logic [2:0] g, input ev_t k, input logic [2:0] b,
                       input logic [1:0] c, input logic s);
    gray_in = g;
    expect_ev(k, b, c, s);
    repeat (4) @(negedge clk);
  endtask

  // Monitor
  always @(negedge clk) begin
    ev_t  k;
    logic ev;
    exp_t e;
    ev = 1'b1;
    k  = EV_LOCK;
    if (step)                         k = EV_STEP;
    else if (back_err)                k = EV_BACK;
    else if (skip_err)                k = EV_SKIP;
    else if (locked && !locked_prev)  k = EV_LOCK;
    else                              ev = 1'b0;
    if (ev) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d bin %0d, expected no event", k, bin_out);
      end else begin
        e = q.pop_front();
        check("ev_kind",   32'(k),          32'(e.kind));
        check("ev_bin",    32'(bin_out),    32'(e.bin));
        check("ev_count",  32'(err_count),  32'(e.cnt));
        check("ev_sticky", 32'(err_sticky), 32'(e.sticky));
      end
    end
    locked_prev = locked;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    gray_in = 3'b000;
    enable  = 1'b1;
    err_clr = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bin",    32'(bin_out),    0);
    check("rst_locked", 32'(locked),     0);
    check("rst_pulses", 32'({step, back_err, skip_err}), 0);
    check("rst_sticky", 32'(err_sticky), 0);
    check("rst_count",  32'(err_count),  0);

    rst = 1'b0;
    expect_ev(EV_LOCK, 3'd0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("lock_not_early", 32'(locked), 0);
    @(negedge clk);
    check("lock_after_3", 32'(locked), 1);

    // Full Gray walk including the 7 -> 0 wrap
    drive(3'b001, EV_STEP, 3'd1, 2'd0, 1'b0);
    drive(3'b011, EV_STEP, 3'd2, 2'd0, 1'b0);
    drive(3'b010, EV_STEP, 3'd3, 2'd0, 1'b0);
    drive(3'b110, EV_STEP, 3'd4, 2'd0, 1'b0);
    drive(3'b111, EV_STEP, 3'd5, 2'd0, 1'b0);
    drive(3'b101, EV_STEP, 3'd6, 2'd0, 1'b0);
    drive(3'b100, EV_STEP, 3'd7, 2'd0, 1'b0);
    drive(3'b000, EV_STEP, 3'd0, 2'd0, 1'b0);
    check("walk_count", 32'(err_count), 0);

    // Backward move 2 -> 1
    drive(3'b001, EV_STEP, 3'd1, 2'd0, 1'b0);
    drive(3'b011, EV_STEP, 3'd2, 2'd0, 1'b0);
    drive(3'b001, EV_BACK, 3'd1, 2'd1, 1'b1);

    // Skip 1 -> 3, then legal step 3 -> 4
    drive(3'b010, EV_SKIP, 3'd3, 2'd2, 1'b1);
    drive(3'b110, EV_STEP, 3'd4, 2'd2, 1'b1);

    // Clear, then saturate the 2-bit counter with five skips
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_count",  32'(err_count),  0);
    check("clr_sticky", 32'(err_sticky), 0);
    drive(3'b101, EV_SKIP, 3'd6, 2'd1, 1'b1);
    drive(3'b000, EV_SKIP, 3'd0, 2'd2, 1'b1);
    drive(3'b011, EV_SKIP, 3'd2, 2'd3, 1'b1);
    drive(3'b110, EV_SKIP, 3'd4, 2'd3, 1'b1);
    drive(3'b101, EV_SKIP, 3'd6, 2'd3, 1'b1);
    check("sat_count",  32'(err_count),  3);
    check("sat_sticky", 32'(err_sticky), 1);

    // Sixth error lands on the same edge as err_clr: the error wins
    gray_in = 3'b000;
    expect_ev(EV_SKIP, 3'd0, 2'd1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr2_count",  32'(err_count),  0);
    check("clr2_sticky", 32'(err_sticky), 0);

    // Disable while the count jumps 0 -> 4, then reacquire without an error
    enable  = 1'b0;
    gray_in = 3'b110;
    repeat (5) @(negedge clk);
    check("dis_locked", 32'(locked),  0);
    check("dis_bin",    32'(bin_out), 0);
    enable = 1'b1;
    expect_ev(EV_LOCK, 3'd4, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("relock_not_early", 32'(locked), 0);
    @(negedge clk);
    check("relock_locked", 32'(locked),    1);
    check("relock_bin",    32'(bin_out),   4);
    check("relock_count",  32'(err_count), 0);

    // Build some error state, then hit rst between edges
    drive(3'b100, EV_SKIP, 3'd7, 2'd1, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_bin",    32'(bin_out),    0);
    check("arst_locked", 32'(locked),     0);
    check("arst_sticky", 32'(err_sticky), 0);
    check("arst_count",  32'(err_count),  0);
    gray_in = 3'b010;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_ev(EV_LOCK, 3'd3, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("arst_relock_not_early", 32'(locked), 0);
    @(negedge clk);
    check("arst_relock_locked", 32'(locked),  1);
    check("arst_relock_bin",    32'(bin_out), 3);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
